// File: rtl/gcd_binary_param_pkg.sv
// Shared types for the binary GCD engine: FSM state encoding and counter sizing.
package gcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_t;

   // Worst case is 2*WIDTH+1 iterations, so the counter must be able to hold that value.
   function automatic int cntWidth(input int width);
      return $clog2(2 * width + 2);
   endfunction

endpackage

// File: rtl/gcd_binary_param_if.sv
// Operand/result handshake bundle for gcd_binary_param.
// cycles_out exists only when GCD_CYCLE_CNT_EN is defined.
interface gcd_binary_param_if
   import gcd_pkg::*;
#(
   parameter int WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] gcd_out;
   logic             coprime;
`ifdef GCD_CYCLE_CNT_EN
   localparam int CNT_W = cntWidth(WIDTH);
   logic [CNT_W-1:0] cycles_out;

   modport master (output in_valid, a_in, b_in, out_ready,
                   input  in_ready, out_valid, gcd_out, coprime, cycles_out);
   modport slave  (input  in_valid, a_in, b_in, out_ready,
                   output in_ready, out_valid, gcd_out, coprime, cycles_out);
`else
   modport master (output in_valid, a_in, b_in, out_ready,
                   input  in_ready, out_valid, gcd_out, coprime);
   modport slave  (input  in_valid, a_in, b_in, out_ready,
                   output in_ready, out_valid, gcd_out, coprime);
`endif

endinterface

// File: rtl/gcd_binary_param_step.sv
// One Stein GCD iteration, purely combinational; the first matching rule wins.
module gcd_step #(
   parameter int WIDTH = 64,
   parameter int K_W   = 7
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [K_W-1:0]   i_k,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [K_W-1:0]   o_k,
   output logic             o_term,
   output logic [WIDTH-1:0] o_result
);

   // The larger operand is always the minuend, so the subtractions never borrow.
   always_comb begin
      o_a      = i_a;
      o_b      = i_b;
      o_k      = i_k;
      o_term   = 1'b0;
      o_result = (i_a | i_b) << i_k;
      if ((i_a == i_b) || (i_a == '0) || (i_b == '0)) begin
         o_term = 1'b1;
      end else if (!i_a[0] && !i_b[0]) begin
         o_a = i_a >> 1;
         o_b = i_b >> 1;
         o_k = i_k + K_W'(1);
      end else if (!i_a[0]) begin
         o_a = i_a >> 1;
      end else if (!i_b[0]) begin
         o_b = i_b >> 1;
      end else if (i_a > i_b) begin
         o_a = (i_a - i_b) >> 1;
      end else begin
         o_b = (i_b - i_a) >> 1;
      end
   end

endmodule

// File: rtl/gcd_binary_param.sv
// Binary (Stein) GCD engine with valid/ready handshakes on both sides.
// Define GCD_CYCLE_CNT_EN to expose the per-job iteration count on cycles_out.
module gcd_binary_param
   import gcd_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = cntWidth(WIDTH)
) (
   input logic               clk,
   input logic               rst,
   gcd_binary_param_if.slave bus
);

   localparam int K_W = $clog2(WIDTH + 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [K_W-1:0]   r_k;
   logic [CNT_W-1:0] r_iter;
   logic [WIDTH-1:0] r_gcd;
   logic             r_coprime;
`ifdef GCD_CYCLE_CNT_EN
   logic [CNT_W-1:0] r_cycles;
`endif

   logic [WIDTH-1:0] w_nextA;
   logic [WIDTH-1:0] w_nextB;
   logic [K_W-1:0]   w_nextK;
   logic             w_term;
   logic [WIDTH-1:0] w_result;

   gcd_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .i_a      (r_a),
      .i_b      (r_b),
      .i_k      (r_k),
      .o_a      (w_nextA),
      .o_b      (w_nextB),
      .o_k      (w_nextK),
      .o_term   (w_term),
      .o_result (w_result)
   );

   // Result registers only load on the terminating step, so they hold through DONE and after.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_k       <= '0;
         r_iter    <= '0;
         r_gcd     <= '0;
         r_coprime <= 1'b0;
`ifdef GCD_CYCLE_CNT_EN
         r_cycles  <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a_in;
                  r_b     <= bus.b_in;
                  r_k     <= '0;
                  r_iter  <= '0;
                  r_state <= COMPUTE;
               end
            end
            COMPUTE: begin
               r_iter <= r_iter + CNT_W'(1);
               if (w_term) begin
                  r_gcd     <= w_result;
                  r_coprime <= (w_result == WIDTH'(1));
`ifdef GCD_CYCLE_CNT_EN
                  r_cycles  <= r_iter + CNT_W'(1);
`endif
                  r_state   <= DONE;
               end else begin
                  r_a <= w_nextA;
                  r_b <= w_nextB;
                  r_k <= w_nextK;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.gcd_out   = r_gcd;
   assign bus.coprime   = r_coprime;
`ifdef GCD_CYCLE_CNT_EN
   assign bus.cycles_out = r_cycles;
`endif

   // Every non-terminating step drops a bit, so the job must end within 2*WIDTH+1 cycles.
   always @(posedge clk) begin
      if (!rst && (r_state == COMPUTE)) begin
         assert (r_iter < CNT_W'(2 * WIDTH + 1));
      end
   end

endmodule

// File: doc/gcd_binary_param.md
# gcd_binary_param

Parametrised binary (Stein) GCD engine, successor to the fixed 32-bit GCD unit in the Paillier key-generation path. It takes two WIDTH-bit unsigned operands over a valid/ready input handshake. It returns gcd(a,b) and a coprime flag over a valid/ready output handshake with back-pressure. Key generation uses it for the gcd(n, λ) and gcd(p-1, q-1) checks at full key width.

## Interface
- WIDTH, 64, operand and result width in bits (≥ 2)
- CNT_W, $clog2(2*WIDTH+2), width of the internal iteration counter and the optional cycle-count port
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands presented
- in_ready  out  1  engine can accept operands
- a_in  in  WIDTH  operand A, unsigned
- b_in  in  WIDTH  operand B, unsigned
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- gcd_out  out  WIDTH  gcd(A,B); gcd(0,0)=0
- coprime  out  1  gcd_out == 1
- cycles_out  out  CNT_W  COMPUTE cycles used; port exists only with GCD_CYCLE_CNT_EN

## Operation
- States: IDLE (reset state), COMPUTE, DONE.
- IDLE: in_ready=1. When in_valid & in_ready, capture a_in, b_in, clear shift count k and the iteration counter, then go to COMPUTE.
- COMPUTE performs one step per cycle, first match wins:
  1. a==b, a==0 or b==0: result = (a|b) << k. Register gcd_out, coprime and cycles_out, then go to DONE. When a==b, a|b==a.
  2. a and b both even: a>>=1, b>>=1, k++.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. a>b: a=(a-b)>>1.
  6. otherwise: b=(b-a)>>1.
- The iteration counter increments on every COMPUTE cycle, including the terminating one.
- The result shift cannot overflow WIDTH, because result<<k ≤ max(A,B).
- k and all shifts are unsigned and logical. Subtraction is WIDTH bits with no borrow, because the larger operand is always the minuend.
- DONE: out_valid=1 and in_ready=0. When out_valid & out_ready, go to IDLE.
- gcd_out, coprime and cycles_out stay stable from out_valid until the next result is registered. They do not change after the handshake.
- in_ready is 0 in COMPUTE and DONE. in_valid in those states is ignored and not queued.
- Reset mid-operation abandons the computation. All registers clear, the state returns to IDLE, and no result is produced.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, gcd_out=0, coprime=0, cycles_out=0.
- in_ready and out_valid are decoded directly from the state register. They have no combinational path from in_valid or out_ready.
- Let the accept edge be E0. COMPUTE spans N cycles and out_valid rises after edge E0+N.
- Bound: 1 ≤ N ≤ 2*WIDTH+1. Every non-terminating step removes at least one bit from a or b.
- With out_ready held high, out_valid is high for exactly one cycle and in_ready returns the next cycle. A minimum of 1 idle cycle separates jobs.
- out_ready low holds DONE indefinitely.

## Configuration
- GCD_CYCLE_CNT_EN defined:
  - cycles_out port present, loaded with N when the result is registered.
  - Used for latency profiling of key generation.
- Not defined:
  - Port absent.
  - The iteration counter remains internal, used only by assertions.
  - Functional behaviour is otherwise identical.

## Structure
- gcd_pkg holds the state enum (IDLE, COMPUTE, DONE) and a function computing CNT_W from WIDTH.
- Sub-module gcd_step: a purely combinational single-iteration datapath.
  - Inputs: a, b, k.
  - Outputs: next a, b, k, a terminate flag and the shifted result.
  - The top holds the FSM, registers and handshake.

## Test plan
- A=48, B=18, out_ready=1 → gcd_out=6, coprime=0, N=6, out_valid rises 6 edges after accept.
- A=B=0x1234, then A=0, B=35 → gcd 0x1234 with N=1, then gcd 35 with N=1. A=B=0 → gcd_out=0, coprime=0.
- WIDTH=64, A=2^63, B=2^62 → gcd_out=2^62, no overflow. Coprime pair A=2^64-1, B=2^64-2 → gcd_out=1, coprime=1, N ≤ 129.
- Back-pressure: out_ready held 0 for 20 cycles → out_valid and gcd_out stable, in_ready=0, in_valid pulses ignored. out_ready=1 → next accept one cycle later.
- rst pulsed mid-COMPUTE → out_valid=0, in_ready=1 immediately, outputs zero. A new job then completes with the correct result.
- Random: 10k operand pairs at WIDTH=32 and WIDTH=128, compared against a reference GCD model. N ≤ 2*WIDTH+1 is asserted each job.
